// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// uart_rx_os: oversampling UART receiver.
//   Frame: start bit, DATA_BIT_LENGTH data bits (LSB first), optional odd/even
//   parity bit, STOP_BITS stop bits. Each bit is a 2-of-3 majority vote taken
//   around the bit centre. Reports parity, framing and break per frame.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   data_rx       serial line, idle high, asynchronous to clk
//   data_out      last received word, LSB = first data bit on the line
//   data_out_done one-cycle pulse, data_out and flags updated
//   parity_err    parity mismatch on last frame (always 0 when PARITY = 0)
//   frame_err     a stop bit of the last frame sampled 0
//   break_det     last frame was all zeros (data, parity, stop bits)
//   busy          receiving a frame (not IDLE / WAIT_IDLE)
module uart_rx_os #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int BAUDRATE        = 115_200,
  parameter int DATA_BIT_LENGTH = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int OVERSAMPLE      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_rx,
  output logic [DATA_BIT_LENGTH-1:0] data_out,
  output logic                       data_out_done,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       break_det,
  output logic                       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  logic                       sync1_q, sync2_q, prev_q;
  logic                       line;
  state_t                     state_q;
  logic [TW-1:0]              tick_q;
  logic [SW-1:0]              s_q;
  logic [1:0]                 samp_q;
  logic [3:0]                 bit_cnt_q;
  logic                       stop_cnt_q;
  logic [DATA_BIT_LENGTH-1:0] shift_q;
  logic                       par_q;
  logic                       ferr_q;
  logic                       stop_hi_q;

  logic tick, vote, vote_tick, wrap_tick;
  logic ferr_d, stop_hi_d, perr_d, brk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= data_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign line = sync2_q;

  always_comb begin
    tick      = (tick_q == TW'(TICK_DIV - 1));
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
    vote_tick = tick && (s_q == S_HI);
    wrap_tick = tick && (s_q == S_LAST);
    ferr_d    = ferr_q | ~vote;
    stop_hi_d = stop_hi_q | vote;
    if (PARITY == 0)      perr_d = 1'b0;
    else if (PARITY == 1) perr_d = ((^shift_q) == par_q);
    else                  perr_d = ((^shift_q) != par_q);
    // par_q stays 0 without a parity bit, so it never blocks break detection
    brk_d     = (shift_q == '0) && !par_q && !stop_hi_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_IDLE;
      tick_q        <= '0;
      s_q           <= '0;
      samp_q        <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      ferr_q        <= 1'b0;
      stop_hi_q     <= 1'b0;
      data_out      <= '0;
      data_out_done <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      break_det     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_out_done <= 1'b0;
      case (state_q)
        ST_WAIT_IDLE: begin
          // s_q doubles as a settle counter: the reset value of the synchroniser
          // must be flushed before a high line counts as genuinely idle.
          tick_q <= '0;
          if (!line) begin
            s_q <= '0;
          end else if (s_q == SW'(2)) begin
            s_q     <= '0;
            state_q <= ST_IDLE;
          end else begin
            s_q <= s_q + 1'b1;
          end
        end
        ST_IDLE: begin
          tick_q <= '0;
          s_q    <= '0;
          if (prev_q && !line) begin
            state_q <= ST_START;
            busy    <= 1'b1;
          end
        end
        default: begin
          tick_q <= tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == S_LO)  samp_q[0] <= line;
            if (s_q == S_MID) samp_q[1] <= line;
          end
          case (state_q)
            ST_START: begin
              if (vote_tick && vote) begin
                state_q <= ST_IDLE;
                busy    <= 1'b0;
              end else if (wrap_tick) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              if (vote_tick) shift_q <= {vote, shift_q[DATA_BIT_LENGTH-1:1]};
              if (wrap_tick) begin
                if (bit_cnt_q == 4'(DATA_BIT_LENGTH - 1)) begin
                  state_q    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  stop_cnt_q <= 1'b0;
                  ferr_q     <= 1'b0;
                  stop_hi_q  <= 1'b0;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                end
              end
            end
            ST_PARITY: begin
              if (vote_tick) par_q <= vote;
              if (wrap_tick) state_q <= ST_STOP;
            end
            ST_STOP: begin
              if (vote_tick) begin
                if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  // Finish at the final stop-bit vote so a start bit right
                  // after the stop bit is still caught as an edge in IDLE.
                  data_out      <= shift_q;
                  parity_err    <= perr_d;
                  frame_err     <= ferr_d;
                  break_det     <= brk_d;
                  data_out_done <= 1'b1;
                  busy          <= 1'b0;
                  tick_q        <= '0;
                  s_q           <= '0;
                  state_q       <= brk_d ? ST_WAIT_IDLE : ST_IDLE;
                end else begin
                  ferr_q    <= ferr_d;
                  stop_hi_q <= stop_hi_d;
                end
              end
              if (wrap_tick) stop_cnt_q <= stop_cnt_q + 1'b1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;

  // 625 kbaud x16 at 100 MHz divides exactly (10 clk per tick, 1600 ns per bit)
  localparam int BAUD   = 625_000;
  localparam int BIT_NS = 1600;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rec_t;

  typedef struct {
    int         id;
    logic [8:0] d;
    bit         pbit;
    bit [1:0]   st;
    int         gap;
    logic [8:0] ed;
    bit         ep, ef, eb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic done0, done1, done2, p0, p1, p2, f0, f1, f2, b0, b1, b2, busy0, busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  rec_t act_q [3][$];
  rec_t exp_q [3][$];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(100_000_000), .BAUDRATE(BAUD), .DATA_BIT_LENGTH(8),
               .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_8n1 (
    .clk(clk), .rst(rst), .data_rx(rx[0]), .data_out(d0), .data_out_done(done0),
    .parity_err(p0), .frame_err(f0), .break_det(b0), .busy(busy0));

  uart_rx_os #(.CLK_FREQ(100_000_000), .BAUDRATE(BAUD), .DATA_BIT_LENGTH(8),
               .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) dut_8e1 (
    .clk(clk), .rst(rst), .data_rx(rx[1]), .data_out(d1), .data_out_done(done1),
    .parity_err(p1), .frame_err(f1), .break_det(b1), .busy(busy1));

  uart_rx_os #(.CLK_FREQ(100_000_000), .BAUDRATE(BAUD), .DATA_BIT_LENGTH(7),
               .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(16)) dut_7o2 (
    .clk(clk), .rst(rst), .data_rx(rx[2]), .data_out(d2), .data_out_done(done2),
    .parity_err(p2), .frame_err(f2), .break_det(b2), .busy(busy2));

  always @(negedge clk) begin
    if (done0) act_q[0].push_back(rec_t'({1'b0, d0, p0, f0, b0}));
    if (done1) act_q[1].push_back(rec_t'({1'b0, d1, p1, f1, b1}));
    if (done2) act_q[2].push_back(rec_t'({2'b0, d2, p2, f2, b2}));
  end

  function automatic int nbits(int id); return (id == 2) ? 7 : 8; endfunction
  function automatic int pmode(int id); return (id == 0) ? 0 : (id == 1) ? 2 : 1; endfunction
  function automatic int nstop(int id); return (id == 2) ? 2 : 1; endfunction
  function automatic logic busy_of(int id);
    return (id == 0) ? busy0 : (id == 1) ? busy1 : busy2;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Reference: decode straight from the bit levels placed on the line
  function automatic rec_t model(int id, logic [8:0] d, bit pbit, bit [1:0] st);
    rec_t r;
    int   ones = 0;
    bit   any_hi = 1'b0;
    for (int i = 0; i < nbits(id); i++) ones += int'(d[i]);
    r.data = d;
    r.perr = (pmode(id) == 1) ? (((ones + int'(pbit)) % 2) != 1) :
             (pmode(id) == 2) ? (((ones + int'(pbit)) % 2) != 0) : 1'b0;
    r.ferr = 1'b0;
    for (int i = 0; i < nstop(id); i++) begin
      if (st[i]) any_hi = 1'b1;
      else       r.ferr = 1'b1;
    end
    r.brk = (ones == 0) && (pmode(id) == 0 || !pbit) && !any_hi;
    return r;
  endfunction

  task automatic send_frame(int id, logic [8:0] d, bit pbit, bit [1:0] st);
    rx[id] = 1'b0; #BIT_NS;
    for (int i = 0; i < nbits(id); i++) begin rx[id] = d[i]; #BIT_NS; end
    if (pmode(id) != 0) begin rx[id] = pbit; #BIT_NS; end
    for (int i = 0; i < nstop(id); i++) begin rx[id] = st[i]; #BIT_NS; end
    rx[id] = 1'b1;
  endtask

  task automatic drain(int id, string tag);
    rec_t e, a;
    while (exp_q[id].size() > 0) begin
      e = exp_q[id].pop_front();
      for (int c = 0; c < 3000 && act_q[id].size() == 0; c++) @(negedge clk);
      if (act_q[id].size() == 0) begin
        chk($sformatf("%s dut%0d pulse timeout", tag, id), 0, 1);
      end else begin
        a = act_q[id].pop_front();
        chk($sformatf("%s dut%0d data_out", tag, id), 32'(a.data), 32'(e.data));
        chk($sformatf("%s dut%0d parity_err", tag, id), 32'(a.perr), 32'(e.perr));
        chk($sformatf("%s dut%0d frame_err", tag, id), 32'(a.ferr), 32'(e.ferr));
        chk($sformatf("%s dut%0d break_det", tag, id), 32'(a.brk), 32'(e.brk));
      end
    end
    chk($sformatf("%s dut%0d extra pulses", tag, id), 32'(act_q[id].size()), 0);
    chk($sformatf("%s dut%0d busy idle", tag, id), 32'(busy_of(id)), 0);
  endtask

  task automatic rand_stream(int id);
    logic [8:0] d;
    bit         pbit;
    bit [1:0]   st;
    for (int k = 0; k < 6; k++) begin
      d    = 9'($urandom) & 9'((1 << nbits(id)) - 1);
      pbit = 1'($urandom_range(0, 1));
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin d = '0; pbit = 1'b0; st = 2'b00; end
      exp_q[id].push_back(model(id, d, pbit, st));
      send_frame(id, d, pbit, st);
      // a low final stop bit needs idle time before the next start edge
      if (!st[nstop(id)-1] || $urandom_range(0, 1) == 1) #BIT_NS;
    end
    #(2 * BIT_NS);
    drain(id, "random");
  endtask

  vec_t vecs[10];
  rec_t a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'h055, 1'b0, 2'b11, 2, 9'h055, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h055, 1'b0, 2'b11, 0, 9'h055, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0A3, 1'b0, 2'b11, 2, 9'h0A3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h0A3, 1'b1, 2'b11, 2, 9'h0A3, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1, 9'h0A3, 1'b0, 2'b11, 2, 9'h0A3, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{0, 9'h03C, 1'b0, 2'b10, 2, 9'h03C, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{2, 9'h05A, 1'b1, 2'b11, 2, 9'h05A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2, 9'h001, 1'b1, 2'b01, 2, 9'h001, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{2, 9'h000, 1'b0, 2'b00, 2, 9'h000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1, 9'h000, 1'b0, 2'b00, 2, 9'h000, 1'b0, 1'b1, 1'b1};

    // reset state
    repeat (5) @(negedge clk);
    chk("reset data_out", 32'(d0), 0);
    chk("reset data_out 7o2", 32'(d2), 0);
    chk("reset flags", 32'({p0, f0, b0, p1, f1, b1}), 0);
    chk("reset done", 32'({done0, done1, done2}), 0);
    chk("reset busy", 32'({busy0, busy1, busy2}), 0);
    rst = 1'b0;
    #(2 * BIT_NS);

    // low line across reset release is not a start bit
    rx[0] = 1'b0; rst = 1'b1; #50; rst = 1'b0;
    #(3 * BIT_NS);
    chk("low after reset busy", 32'(busy0), 0);
    rx[0] = 1'b1;
    #(2 * BIT_NS);
    chk("low after reset pulses", 32'(act_q[0].size()), 0);

    // directed frame table
    foreach (vecs[i]) begin
      exp_q[vecs[i].id].push_back('{vecs[i].ed, vecs[i].ep, vecs[i].ef, vecs[i].eb});
      send_frame(vecs[i].id, vecs[i].d, vecs[i].pbit, vecs[i].st);
      if (vecs[i].gap > 0) begin
        #(vecs[i].gap * BIT_NS);
        drain(vecs[i].id, $sformatf("vec%0d", i));
      end
    end

    // short low glitch while idle
    rx[0] = 1'b0; #200;
    chk("glitch busy high", 32'(busy0), 1);
    #170; rx[0] = 1'b1;
    #(2 * BIT_NS);
    chk("glitch busy low", 32'(busy0), 0);
    chk("glitch no pulse", 32'(act_q[0].size()), 0);

    // long break: exactly one pulse
    rx[0] = 1'b0; #(20 * BIT_NS); rx[0] = 1'b1;
    #(2 * BIT_NS);
    chk("break pulse count", 32'(act_q[0].size()), 1);
    if (act_q[0].size() > 0) begin
      a = act_q[0].pop_front();
      chk("break data_out", 32'(a.data), 0);
      chk("break flags", 32'({a.perr, a.ferr, a.brk}), 32'b011);
    end
    act_q[0].delete();
    exp_q[0].push_back('{9'h041, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h041, 1'b0, 2'b11);
    #(2 * BIT_NS);
    drain(0, "after break");

    // reset during data bit 4
    rx[0] = 1'b0; #BIT_NS;
    for (int i = 0; i < 4; i++) begin rx[0] = (i % 2 == 0); #BIT_NS; end
    rx[0] = 1'b1; #(BIT_NS / 2);
    chk("midframe busy", 32'(busy0), 1);
    rst = 1'b1; #50;
    chk("midframe reset data_out", 32'(d0), 0);
    chk("midframe reset flags", 32'({p0, f0, b0, done0, busy0}), 0);
    rst = 1'b0;
    #(2 * BIT_NS);
    chk("midframe no pulse", 32'(act_q[0].size()), 0);
    exp_q[0].push_back('{9'h07E, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h07E, 1'b0, 2'b11);
    #(2 * BIT_NS);
    drain(0, "after reset");

    // randomized streams on all three builds in parallel
    fork
      rand_stream(0);
      rand_stream(1);
      rand_stream(2);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
